// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: FSM states, RV32I opcodes and ALU-op codes for the multicycle controller
// CTRL_JUMP_EN widens the legal opcode set with LUI/AUIPC/JAL/JALR.
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FN    = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;
    function automatic logic is_jump(input logic [6:0] op);
        return op == OP_JAL || op == OP_JALR;
    endfunction
    function automatic logic is_legal(input logic [6:0] op);
`ifdef CTRL_JUMP_EN
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
`else
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
`endif
    endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the controller (master) and the datapath (slave)
interface multicycle_controller_if #(parameter int ADDR_HI_W = 22);
    logic [6:0]           opcode;
    logic [ADDR_HI_W-1:0] alu_result_high;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 ir_write;
    logic [1:0]           alu_op;
    logic                 alu_src;
    logic                 mem_read;
    logic                 mem_write;
    logic                 io_read;
    logic                 io_write;
    logic                 mem_or_io_to_reg;
    logic                 reg_write;
    logic                 illegal;
    logic                 bus_err;
    logic [2:0]           state;
    modport master (
        input  opcode, alu_result_high, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, alu_op, alu_src, mem_read, mem_write,
               io_read, io_write, mem_or_io_to_reg, reg_write, illegal, bus_err, state
    );
    modport slave (
        output opcode, alu_result_high, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, alu_op, alu_src, mem_read, mem_write,
               io_read, io_write, mem_or_io_to_reg, reg_write, illegal, bus_err, state
    );
endinterface

// File: rtl/multicycle_controller_mem_waiter.sv
// ctrl_mem_waiter: counts MEM cycles spent waiting on mem_ready and flags the timeout cycle
module ctrl_mem_waiter #(
    parameter int WAIT_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int CW = $clog2(WAIT_MAX) > 0 ? $clog2(WAIT_MAX) : 1;
    logic [CW-1:0] cnt;
    assign timeout = active && !ready && cnt == CW'(WAIT_MAX - 1);
    // Clears on any MEM exit: ready, timeout, or leaving the state.
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (active && !ready && !timeout) ? cnt + CW'(1) : '0;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I IF/ID/EX/MEM/WB control FSM with MMIO decode and mem_ready timeout
// Define CTRL_JUMP_EN to accept LUI/AUIPC/JAL/JALR.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int                   ADDR_HI_W  = 22,
    parameter logic [ADDR_HI_W-1:0] IO_BASE_HI = 22'h3FFFFF,
    parameter int                   WAIT_MAX   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    state_t     st, nx;
    logic [6:0] op_q;
    logic       io_q, ill_q, err_q, timeout;
    logic       is_ld, is_st, is_mem;
    assign is_ld  = op_q == OP_LOAD;
    assign is_st  = op_q == OP_STORE;
    assign is_mem = is_ld || is_st;
    ctrl_mem_waiter #(.WAIT_MAX(WAIT_MAX)) u_waiter (
        .clk     (clk),
        .rst     (rst),
        .active  (st == S_MEM && !io_q),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st    <= S_IF;
            op_q  <= 7'h00;
            io_q  <= 1'b0;
            ill_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st    <= nx;
            ill_q <= st == S_ID && !is_legal(bus.opcode);
            err_q <= timeout;
            if (st == S_ID) op_q <= bus.opcode;
            if (st == S_EX && is_mem) io_q <= bus.alu_result_high == IO_BASE_HI;
        end
    always_comb begin
        nx = S_IF;
        case (st)
            S_IF:  nx = S_ID;
            S_ID:  nx = is_legal(bus.opcode) ? S_EX : S_IF;
            S_EX:  nx = is_mem ? S_MEM : (op_q == OP_BRANCH ? S_IF : S_WB);
            S_MEM: nx = (io_q || bus.mem_ready) ? (is_ld ? S_WB : S_IF) : (timeout ? S_IF : S_MEM);
            default: nx = S_IF;
        endcase
    end
    // Outputs decode the registered state; reset forces them low combinationally.
    always_comb begin
        bus.pc_write         = 1'b0;
        bus.pc_write_cond    = 1'b0;
        bus.ir_write         = 1'b0;
        bus.alu_op           = ALU_ADD;
        bus.alu_src          = 1'b0;
        bus.mem_read         = 1'b0;
        bus.mem_write        = 1'b0;
        bus.io_read          = 1'b0;
        bus.io_write         = 1'b0;
        bus.mem_or_io_to_reg = 1'b0;
        bus.reg_write        = 1'b0;
        bus.illegal          = ill_q;
        bus.bus_err          = err_q;
        bus.state            = st;
        if (!rst)
            case (st)
                S_IF: begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end
                S_EX: begin
                    bus.alu_op = is_mem ? ALU_ADD : op_q == OP_BRANCH ? ALU_BR :
                                 (op_q == OP_R || op_q == OP_I) ? ALU_FN : ALU_PASS;
                    bus.alu_src = op_q != OP_R && op_q != OP_BRANCH;
`ifdef CTRL_JUMP_EN
                    bus.pc_write_cond = op_q == OP_BRANCH ? bus.zero : is_jump(op_q);
`else
                    bus.pc_write_cond = op_q == OP_BRANCH && bus.zero;
`endif
                end
                S_MEM: begin
                    bus.mem_read  = !io_q && is_ld;
                    bus.mem_write = !io_q && is_st;
                    bus.io_read   = io_q && is_ld;
                    bus.io_write  = io_q && is_st;
                end
                S_WB: begin
                    bus.reg_write        = 1'b1;
                    bus.mem_or_io_to_reg = is_ld;
                end
                default: ;
            endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction traces checked against a per-instruction cycle model
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   pend_ill = 1'b0;
    bit   pend_err = 1'b0;
    always #5 clk = ~clk;
    multicycle_controller_if #(.ADDR_HI_W(22)) bus ();
    multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic [16:0] exp;
        logic        rdy;
    } cyc_t;
    cyc_t q[$];
    // Flag layout below the 3-bit state: pcw pcc irw aop[2] src mr mw ior iow m2r rw ill err
    function automatic logic [16:0] obs_v();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.alu_op, bus.alu_src,
                bus.mem_read, bus.mem_write, bus.io_read, bus.io_write, bus.mem_or_io_to_reg,
                bus.reg_write, bus.illegal, bus.bus_err};
    endfunction
    task automatic check(input string tag, input logic [16:0] exp);
        checks++;
        assert (obs_v() === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs_v(), exp);
        end
    endtask
    function automatic bit legal_m(input logic [6:0] op);
        bit base = op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                   op == 7'b0100011 || op == 7'b1100011;
`ifdef CTRL_JUMP_EN
        return base || op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111;
`else
        return base;
`endif
    endfunction
    task automatic push(input int st, input logic [13:0] f, input logic rdy);
        q.push_back(cyc_t'{exp: {3'(st), f}, rdy: rdy});
    endtask
    // Expected cycle-by-cycle trace of one instruction; lat = MEM cycle on which mem_ready rises (0 = never).
    task automatic build(input logic [6:0] op, input logic [21:0] high, input logic z, input int lat);
        logic [13:0] f;
        bit ld, sto, br, jmp, rfn;
        int n;
        q.delete();
        f = '0; f[13] = 1'b1; f[11] = 1'b1; f[1] = pend_ill; f[0] = pend_err;
        push(0, f, 1'b0);
        pend_ill = 1'b0;
        pend_err = 1'b0;
        push(1, '0, 1'b0);
        if (!legal_m(op)) begin
            pend_ill = 1'b1;
            return;
        end
        ld  = op == 7'b0000011;
        sto = op == 7'b0100011;
        br  = op == 7'b1100011;
        rfn = op == 7'b0110011 || op == 7'b0010011;
        jmp = op == 7'b1101111 || op == 7'b1100111;
        f = '0;
        f[10:9] = (ld || sto) ? 2'd0 : br ? 2'd1 : rfn ? 2'd2 : 2'd3;
        f[8]    = !(op == 7'b0110011 || br);
        f[12]   = br ? z : jmp;
        push(2, f, 1'b0);
        if (br) return;
        if (ld || sto) begin
            if (high == 22'h3FFFFF) begin
                f = '0; f[5] = ld; f[4] = sto;
                push(3, f, 1'b0);
            end else begin
                n = (lat >= 1 && lat <= 8) ? lat : 8;
                for (int i = 1; i <= n; i++) begin
                    f = '0; f[7] = ld; f[6] = sto;
                    push(3, f, i == lat);
                end
                if (lat < 1 || lat > 8) begin
                    pend_err = 1'b1;
                    return;
                end
            end
            if (sto) return;
        end
        f = '0; f[2] = 1'b1; f[3] = ld;
        push(4, f, 1'b0);
    endtask
    // Entered and left at 1 time unit after a rising edge with the DUT in IF.
    task automatic run(input string name, input logic [6:0] op, input logic [21:0] high,
                       input logic z, input int lat, input int abort_at);
        build(op, high, z, lat);
        for (int i = 0; i < q.size(); i++) begin
            bus.opcode          = op;
            bus.alu_result_high = high;
            bus.zero            = z;
            bus.mem_ready       = q[i].rdy;
            if (i == abort_at) begin
                #1 check($sformatf("%s pre_rst c%0d", name, i), q[i].exp);
                rst = 1'b1;
                #1 check($sformatf("%s rst_abort", name), 17'h0);
                @(posedge clk);
                #1 rst = 1'b0;
                pend_ill = 1'b0;
                pend_err = 1'b0;
                return;
            end
            @(negedge clk);
            check($sformatf("%s c%0d", name, i), q[i].exp);
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        logic [6:0] ops [10];
        logic [6:0] op;
        logic [21:0] high;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'h00};
        bus.opcode          = 7'h00;
        bus.alu_result_high = '0;
        bus.zero            = 1'b0;
        bus.mem_ready       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset", 17'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        run("r_type",    7'b0110011, 22'h000001, 1'b0, 0, -1);
        run("load_wait", 7'b0000011, 22'h000001, 1'b0, 3, -1);
        run("store_io",  7'b0100011, 22'h3FFFFF, 1'b0, 0, -1);
        run("load_io",   7'b0000011, 22'h3FFFFF, 1'b0, 0, -1);
        run("load_tmo",  7'b0000011, 22'h000010, 1'b0, 0, -1);
        run("load_edge", 7'b0000011, 22'h000010, 1'b0, 8, -1);
        run("store_mem", 7'b0100011, 22'h3FFFFE, 1'b0, 1, -1);
        run("branch_t",  7'b1100011, 22'h000000, 1'b1, 0, -1);
        run("branch_nt", 7'b1100011, 22'h000000, 1'b0, 0, -1);
        run("jal",       7'b1101111, 22'h000000, 1'b0, 0, -1);
        run("i_alu",     7'b0010011, 22'h000000, 1'b0, 0, -1);
        run("junk_op",   7'b1111111, 22'h000000, 1'b0, 0, -1);
        run("mid_rst",   7'b0100011, 22'h000020, 1'b0, 0, 4);
        run("after_rst", 7'b0110011, 22'h000000, 1'b0, 0, -1);
        for (int k = 0; k < 200; k++) begin
            op   = ops[$urandom_range(0, 9)];
            if (op == 7'h00) op = 7'($urandom);
            high = $urandom_range(0, 1) ? 22'h3FFFFF : 22'($urandom);
            run("rand", op, high, 1'($urandom), $urandom_range(0, 10), -1);
        end
        run("flush", 7'b0110011, 22'h000000, 1'b0, 0, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
